// File: rtl/adc_to_opfb_hls_deadlock_report_unit.sv
// Deadlock supervisor: confirms a persistent detect, launches a token walk from one origin,
// traces the cycle through returned tokens and latches a report until the host acknowledges.
module adc_to_opfb_hls_deadlock_report_unit #(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 8,
    parameter int TIMEOUT        = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [PROC_NUM-1:0]         dl_detect_vec,
    input  logic [PROC_NUM-1:0]         token_vec,
    input  logic                        dl_ack,
    output logic [PROC_NUM-1:0]         origin_vec,
    output logic                        dl_detect_in,
    output logic                        token_clear,
    output logic                        dl_valid,
    output logic [$clog2(PROC_NUM)-1:0] dl_origin_id,
    output logic [PROC_NUM-1:0]         dl_path,
    output logic [7:0]                  dl_hop_cnt,
    output logic                        dl_timeout
);
    localparam int ID_W  = $clog2(PROC_NUM);
    localparam int CNT_W = $clog2(CONFIRM_CYCLES + 1);
    localparam int TR_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CONFIRM, TRACE, REPORT} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     origin_q, origin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TR_W-1:0]     trace_cnt_q, trace_cnt_d;
    logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;
    logic                dl_detect_in_q, dl_detect_in_d;
    logic                dl_valid_q, dl_valid_d;
    logic [ID_W-1:0]     dl_origin_id_q, dl_origin_id_d;
    logic [PROC_NUM-1:0] dl_path_q, dl_path_d;
    logic [7:0]          dl_hop_cnt_q, dl_hop_cnt_d;
    logic                dl_timeout_q, dl_timeout_d;
    logic                enter_trace;

    function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
        lowest_idx = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

    always_comb begin
        state_d        = state_q;
        origin_d       = origin_q;
        cnt_d          = cnt_q;
        trace_cnt_d    = trace_cnt_q;
        origin_vec_d   = '0;
        dl_detect_in_d = dl_detect_in_q;
        dl_valid_d     = dl_valid_q;
        dl_origin_id_d = dl_origin_id_q;
        dl_path_d      = dl_path_q;
        dl_hop_cnt_d   = dl_hop_cnt_q;
        dl_timeout_d   = dl_timeout_q;
        token_clear    = 1'b0;
        enter_trace    = 1'b0;

        case (state_q)
            IDLE: begin
                if (|dl_detect_vec) begin
                    origin_d = lowest_idx(dl_detect_vec);
                    if (CONFIRM_CYCLES == 1) begin
                        enter_trace = 1'b1;
                    end else begin
                        state_d = CONFIRM;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            CONFIRM: begin
                // Only the latched origin's detect matters; other units may come and go.
                if (!dl_detect_vec[origin_q]) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(CONFIRM_CYCLES)) enter_trace = 1'b1;
                end
            end
            TRACE: begin
                dl_path_d   = dl_path_q | token_vec;
                trace_cnt_d = trace_cnt_q + TR_W'(1);
                if ((|token_vec) && (dl_hop_cnt_q != 8'hFF)) dl_hop_cnt_d = dl_hop_cnt_q + 8'd1;
                // A token still at the origin in cycle 0 is the launch, not a return.
                if ((trace_cnt_q != '0) && token_vec[origin_q]) begin
                    token_clear  = 1'b1;
                    state_d      = REPORT;
                    dl_valid_d   = 1'b1;
                    dl_timeout_d = 1'b0;
                end else if (trace_cnt_q == TR_W'(TIMEOUT - 1)) begin
                    token_clear  = 1'b1;
                    state_d      = REPORT;
                    dl_valid_d   = 1'b1;
                    dl_timeout_d = 1'b1;
                end
            end
            REPORT: begin
                if (dl_ack) begin
                    state_d        = IDLE;
                    dl_valid_d     = 1'b0;
                    dl_detect_in_d = 1'b0;
                    dl_origin_id_d = '0;
                    dl_path_d      = '0;
                    dl_hop_cnt_d   = '0;
                    dl_timeout_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_trace) begin
            state_d        = TRACE;
            trace_cnt_d    = '0;
            origin_vec_d   = PROC_NUM'(1) << origin_d;
            dl_detect_in_d = 1'b1;
            dl_origin_id_d = origin_d;
            dl_path_d      = PROC_NUM'(1) << origin_d;
            dl_hop_cnt_d   = '0;
            dl_timeout_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            origin_q       <= '0;
            cnt_q          <= '0;
            trace_cnt_q    <= '0;
            origin_vec_q   <= '0;
            dl_detect_in_q <= 1'b0;
            dl_valid_q     <= 1'b0;
            dl_origin_id_q <= '0;
            dl_path_q      <= '0;
            dl_hop_cnt_q   <= '0;
            dl_timeout_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            origin_q       <= origin_d;
            cnt_q          <= cnt_d;
            trace_cnt_q    <= trace_cnt_d;
            origin_vec_q   <= origin_vec_d;
            dl_detect_in_q <= dl_detect_in_d;
            dl_valid_q     <= dl_valid_d;
            dl_origin_id_q <= dl_origin_id_d;
            dl_path_q      <= dl_path_d;
            dl_hop_cnt_q   <= dl_hop_cnt_d;
            dl_timeout_q   <= dl_timeout_d;
        end
    end

    assign origin_vec   = origin_vec_q;
    assign dl_detect_in = dl_detect_in_q;
    assign dl_valid     = dl_valid_q;
    assign dl_origin_id = dl_origin_id_q;
    assign dl_path      = dl_path_q;
    assign dl_hop_cnt   = dl_hop_cnt_q;
    assign dl_timeout   = dl_timeout_q;

endmodule

// File: tb/tb_adc_to_opfb_hls_deadlock_report_unit.sv
// Scoreboard bench: the driver computes each episode's report from the token trace and queues it;
// a monitor tracks the DUT's trace/report phases and checks against the queue.
module tb_adc_to_opfb_hls_deadlock_report_unit;
    localparam int P  = 4;
    localparam int CC = 8;
    localparam int TO = 64;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_detect_vec, token_vec;
    logic       dl_ack;
    logic [3:0] origin_vec;
    logic       dl_detect_in, token_clear, dl_valid;
    logic [1:0] dl_origin_id;
    logic [3:0] dl_path;
    logic [7:0] dl_hop_cnt;
    logic       dl_timeout;

    adc_to_opfb_hls_deadlock_report_unit #(.PROC_NUM(P), .CONFIRM_CYCLES(CC), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec), .token_vec(token_vec),
        .dl_ack(dl_ack), .origin_vec(origin_vec), .dl_detect_in(dl_detect_in),
        .token_clear(token_clear), .dl_valid(dl_valid), .dl_origin_id(dl_origin_id),
        .dl_path(dl_path), .dl_hop_cnt(dl_hop_cnt), .dl_timeout(dl_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] ovec;
        logic [1:0] id;
        logic [3:0] path;
        logic [7:0] hop;
        logic       tmo;
        int         tlen;
        bit         abort;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] tv[TO];
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Token trace with the first return to the origin at cycle ret_k (ret_k >= TO means never).
    task automatic gen_tv(input logic [3:0] v, input int ret_k);
        logic [3:0] lb;
        lb = v & (~v + 4'd1);
        for (int k = 0; k < TO; k++) begin
            if (k == 0)          tv[k] = 4'($urandom);
            else if (k < ret_k)  tv[k] = ($urandom_range(0, 1) == 1) ? (4'($urandom) & ~lb) : 4'b0;
            else if (k == ret_k) tv[k] = lb | (4'($urandom) & ~lb);
            else                 tv[k] = 4'b0;
        end
    endtask

    task automatic episode(input logic [3:0] v, input int rst_at);
        logic [3:0] lb, path;
        int oid, hop, end_k, cyc;
        bit tmo;
        exp_t e;
        lb  = v & (~v + 4'd1);
        oid = 0;
        for (int i = 0; i < P; i++) if (lb == 4'(1 << i)) oid = i;
        path = lb; hop = 0; end_k = TO - 1; tmo = 1'b1;
        for (int k = 0; k < TO; k++) begin
            path = path | tv[k];
            if (tv[k] != 4'b0) hop++;
            if (k >= 1 && (tv[k] & lb) != 4'b0) begin
                end_k = k; tmo = 1'b0;
                break;
            end
        end
        e.ovec = lb; e.id = 2'(oid); e.path = path; e.hop = 8'(hop); e.tmo = tmo;
        e.tlen = end_k + 1; e.abort = (rst_at >= 0);
        sb.push_back(e);

        dl_detect_vec = v;
        cyc = 0;
        do begin
            dl_ack = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            cyc++;
        end while (origin_vec == 4'b0 && cyc < 40);
        check("confirm_len", 32'(cyc), 32'(CC));

        for (int k = 0; k <= end_k; k++) begin
            dl_detect_vec = 4'($urandom);
            dl_ack        = 1'($urandom_range(0, 1));
            if (k == rst_at) begin
                token_vec = tv[k] | lb;
                reset     = 1'b1;
                @(posedge clock); #1;
                check("rst_trace_detect_in", 32'(dl_detect_in), 32'(0));
                check("rst_trace_token_clear", 32'(token_clear), 32'(0));
                check("rst_trace_origin_vec", 32'(origin_vec), 32'(0));
                check("rst_trace_valid", 32'(dl_valid), 32'(0));
                reset = 1'b0; token_vec = 4'b0; dl_detect_vec = 4'b0; dl_ack = 1'b0;
                @(posedge clock); #1;
                return;
            end
            token_vec = tv[k];
            @(posedge clock); #1;
        end
        token_vec = 4'b0; dl_ack = 1'b0;
        repeat ($urandom_range(1, 4)) begin
            dl_detect_vec = 4'($urandom);
            @(posedge clock); #1;
        end
        dl_detect_vec = 4'b0;
        dl_ack = 1'b1;
        @(posedge clock); #1;
        dl_ack = 1'b0;
    endtask

    // Monitor state
    bit         in_ep, rep;
    int         tlen, clr, ovc, ov_at;
    logic [3:0] ov;
    exp_t       e_m, snap;

    initial begin : monitor
        in_ep = 0; rep = 0; tlen = 0; clr = 0; ovc = 0; ov_at = 0; ov = 4'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (in_ep) begin
                    checks++;
                    if (sb.size() == 0 || !sb[0].abort) begin
                        errors++;
                        $display("FAIL abort_expected: got trace interrupted by reset required report");
                    end
                    if (sb.size() != 0) void'(sb.pop_front());
                end
                in_ep = 0; rep = 0;
                continue;
            end
            checks++;
            if (((origin_vec != 4'b0 || token_clear) && !(dl_detect_in && !dl_valid)) ||
                (dl_valid && !dl_detect_in)) begin
                errors++;
                $display("FAIL phase_invariant: got ov=%0h clr=%0b din=%0b vld=%0b required strobes only in trace",
                         origin_vec, token_clear, dl_detect_in, dl_valid);
            end
            if (dl_detect_in && !in_ep) begin
                in_ep = 1; rep = 0; tlen = 0; clr = 0; ovc = 0; ov_at = 0; ov = 4'b0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_episode: got dl_detect_in=1 required 0");
                end
            end
            if (in_ep && !rep) begin
                if (!dl_valid) begin
                    tlen++;
                    if (token_clear) clr++;
                    if (origin_vec != 4'b0) begin
                        ovc++; ov = origin_vec; ov_at = tlen;
                    end
                end else begin
                    rep = 1;
                    snap.id = dl_origin_id; snap.path = dl_path; snap.hop = dl_hop_cnt; snap.tmo = dl_timeout;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL report_unexpected: got dl_valid=1 required 0");
                    end else begin
                        e_m = sb.pop_front();
                        check("abort_flag", 32'(e_m.abort), 32'(0));
                        check("origin_id", 32'(dl_origin_id), 32'(e_m.id));
                        check("path", 32'(dl_path), 32'(e_m.path));
                        check("hop_cnt", 32'(dl_hop_cnt), 32'(e_m.hop));
                        check("timeout", 32'(dl_timeout), 32'(e_m.tmo));
                        check("trace_len", 32'(tlen), 32'(e_m.tlen));
                        check("token_clear_cnt", 32'(clr), 32'(1));
                        check("origin_vec_cnt", 32'(ovc), 32'(1));
                        check("origin_vec_val", 32'(ov), 32'(e_m.ovec));
                        check("origin_vec_first", 32'(ov_at), 32'(1));
                        check("detect_in_report", 32'(dl_detect_in), 32'(1));
                    end
                end
            end else if (rep) begin
                if (dl_valid) begin
                    check("report_frozen", {8'h0, dl_hop_cnt, 7'h0, dl_timeout, 2'h0, dl_origin_id, dl_path},
                          {8'h0, snap.hop, 7'h0, snap.tmo, 2'h0, snap.id, snap.path});
                end else begin
                    check("ack_cleared", {8'h0, dl_hop_cnt, 6'h0, dl_detect_in, dl_timeout, 2'h0, dl_origin_id, dl_path},
                          32'h0);
                    rep = 0; in_ep = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int ret_k;
        logic [3:0] v;
        reset = 1'b1; dl_detect_vec = 4'hF; token_vec = 4'b0; dl_ack = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        check("rst_origin_vec", 32'(origin_vec), 32'(0));
        check("rst_detect_in", 32'(dl_detect_in), 32'(0));
        check("rst_token_clear", 32'(token_clear), 32'(0));
        check("rst_valid", 32'(dl_valid), 32'(0));
        check("rst_report", {8'h0, dl_hop_cnt, 7'h0, dl_timeout, 2'h0, dl_origin_id, dl_path}, 32'h0);
        reset = 1'b0; dl_detect_vec = 4'b0;
        @(posedge clock); #1;
        check("post_rst_detect_in", 32'(dl_detect_in), 32'(0));
        repeat (4) @(posedge clock);
        #1;

        // False alarms: 5 cycles, and 7 cycles (one short of confirmation).
        dl_detect_vec = 4'b0100;
        repeat (5) begin @(posedge clock); #1; end
        dl_detect_vec = 4'b0;
        repeat (12) begin @(posedge clock); #1; end
        dl_detect_vec = 4'b1001;
        repeat (CC - 1) begin @(posedge clock); #1; end
        dl_detect_vec = 4'b0;
        repeat (12) begin @(posedge clock); #1; end
        check("false_alarm_detect_in", 32'(dl_detect_in), 32'(0));

        // Directed cycle 1 -> 2 -> 3 -> 1.
        for (int k = 0; k < TO; k++) tv[k] = 4'b0;
        tv[1] = 4'b0100; tv[2] = 4'b1000; tv[3] = 4'b0010;
        episode(4'b0110, -1);

        gen_tv(4'b1000, 1000);  episode(4'b1000, -1);   // never returns
        gen_tv(4'b0101, TO - 1); episode(4'b0101, -1);  // returns on the timeout cycle
        gen_tv(4'b0011, 1000);  episode(4'b0011, 5);    // reset mid-trace

        for (int n = 0; n < 12; n++) begin
            v     = 4'($urandom_range(1, 15));
            ret_k = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(1, 20);
            gen_tv(v, ret_k);
            episode(v, -1);
        end

        repeat (5) begin @(posedge clock); #1; end
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
